// File: rtl/multiplier_fp_9x16_bit_pkg.sv
// Shared constants for the nine-lane Q4.12 fixed-point multiplier.
// Holds word/fraction widths, saturation limits and FSM state encodings.
package multiplier_fp_9x16_bit_pkg;

    localparam int unsigned N     = 16;
    localparam int unsigned Q     = 12;
    localparam int unsigned LANES = 9;

    localparam logic [N-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [N-1:0] SAT_MIN = 16'h8000;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CALC = 1'b1;

endpackage

// File: rtl/multiplier_fp_16_bit.sv
// Combinational signed fixed-point multiply: full 2N-bit product,
// arithmetic shift right by Q (floor), then saturate to N bits.
module multiplier_fp_16_bit
    import multiplier_fp_9x16_bit_pkg::*;
#(
    parameter int unsigned N = multiplier_fp_9x16_bit_pkg::N,
    parameter int unsigned Q = multiplier_fp_9x16_bit_pkg::Q
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] p
);

    logic signed [2*N-1:0] full_prod;
    logic signed [2*N-1:0] shifted;
    logic                  sat_hi;
    logic                  sat_lo;

    always_comb begin
        full_prod = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});
        shifted   = full_prod >>> Q;
        // Result fits only if bits [2N-1:N-1] are all copies of the sign.
        sat_hi    = !shifted[2*N-1] && (shifted[2*N-2:N-1] != '0);
        sat_lo    =  shifted[2*N-1] && (shifted[2*N-2:N-1] != '1);
        if (sat_hi) begin
            p = N'(SAT_MAX);
        end else if (sat_lo) begin
            p = N'(SAT_MIN);
        end else begin
            p = shifted[N-1:0];
        end
    end

endmodule

// File: rtl/multiplier_fp_9x16_bit.sv
// Nine-lane registered Q4.12 multiplier: operands captured on accept,
// all nine saturated products written together one cycle later.
module multiplier_fp_9x16_bit
    import multiplier_fp_9x16_bit_pkg::*;
#(
    parameter int unsigned N = multiplier_fp_9x16_bit_pkg::N,
    parameter int unsigned Q = multiplier_fp_9x16_bit_pkg::Q
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] a2,
    input  logic [N-1:0] a3,
    input  logic [N-1:0] a4,
    input  logic [N-1:0] a5,
    input  logic [N-1:0] a6,
    input  logic [N-1:0] a7,
    input  logic [N-1:0] a8,
    input  logic [N-1:0] a9,
    input  logic [N-1:0] b1,
    input  logic [N-1:0] b2,
    input  logic [N-1:0] b3,
    input  logic [N-1:0] b4,
    input  logic [N-1:0] b5,
    input  logic [N-1:0] b6,
    input  logic [N-1:0] b7,
    input  logic [N-1:0] b8,
    input  logic [N-1:0] b9,
    output logic [N-1:0] o1,
    output logic [N-1:0] o2,
    output logic [N-1:0] o3,
    output logic [N-1:0] o4,
    output logic [N-1:0] o5,
    output logic [N-1:0] o6,
    output logic [N-1:0] o7,
    output logic [N-1:0] o8,
    output logic [N-1:0] o9,
    output logic         busy
);

    logic [0:0]   state_q, state_d;
    logic [N-1:0] a_in [LANES];
    logic [N-1:0] b_in [LANES];
    logic [N-1:0] a_q  [LANES];
    logic [N-1:0] a_d  [LANES];
    logic [N-1:0] b_q  [LANES];
    logic [N-1:0] b_d  [LANES];
    logic [N-1:0] o_q  [LANES];
    logic [N-1:0] o_d  [LANES];
    logic [N-1:0] prod [LANES];

    assign a_in[0] = a1;
    assign a_in[1] = a2;
    assign a_in[2] = a3;
    assign a_in[3] = a4;
    assign a_in[4] = a5;
    assign a_in[5] = a6;
    assign a_in[6] = a7;
    assign a_in[7] = a8;
    assign a_in[8] = a9;
    assign b_in[0] = b1;
    assign b_in[1] = b2;
    assign b_in[2] = b3;
    assign b_in[3] = b4;
    assign b_in[4] = b5;
    assign b_in[5] = b6;
    assign b_in[6] = b7;
    assign b_in[7] = b8;
    assign b_in[8] = b9;

    // Products are taken from the captured operands, so inputs may change freely while busy.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        multiplier_fp_16_bit #(
            .N(N),
            .Q(Q)
        ) u_mul (
            .a(a_q[g]),
            .b(b_q[g]),
            .p(prod[g])
        );
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        o_d     = o_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                o_d     = prod;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            for (int unsigned i = 0; i < LANES; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                o_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            o_q     <= o_d;
        end
    end

    assign busy = (state_q == ST_CALC);
    assign o1   = o_q[0];
    assign o2   = o_q[1];
    assign o3   = o_q[2];
    assign o4   = o_q[3];
    assign o5   = o_q[4];
    assign o6   = o_q[5];
    assign o7   = o_q[6];
    assign o8   = o_q[7];
    assign o9   = o_q[8];

endmodule

// File: tb/tb_multiplier_fp_9x16_bit.sv
// Scoreboard bench for the nine-lane Q4.12 multiplier: stimulus pushes
// expected results on acceptance, a monitor checks outputs every cycle.
module tb_multiplier_fp_9x16_bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a [9];
    logic [15:0] b [9];
    logic [15:0] o [9];
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    logic [143:0] exp_q [$];
    bit           model_busy = 1'b0;

    always #5 clk = ~clk;

    multiplier_fp_9x16_bit #(
        .N(16),
        .Q(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a1(a[0]), .a2(a[1]), .a3(a[2]), .a4(a[3]), .a5(a[4]),
        .a6(a[5]), .a7(a[6]), .a8(a[7]), .a9(a[8]),
        .b1(b[0]), .b2(b[1]), .b3(b[2]), .b4(b[3]), .b5(b[4]),
        .b6(b[5]), .b7(b[6]), .b8(b[7]), .b9(b[8]),
        .o1(o[0]), .o2(o[1]), .o3(o[2]), .o4(o[3]), .o5(o[4]),
        .o6(o[5]), .o7(o[6]), .o8(o[7]), .o9(o[8]),
        .busy(busy)
    );

    // Real-valued meaning: floor(x*y / 4096) clamped to the signed 16-bit range.
    function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        p = p >>> 12;
        if (p > 32767) p = 32767;
        else if (p < -32768) p = -32768;
        return p[15:0];
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'($urandom_range(0, 8)) - 16'd4;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [143:0] outs_packed();
        logic [143:0] v;
        for (int i = 0; i < 9; i++) v[16*i +: 16] = o[i];
        return v;
    endfunction

    // One clock: model the accept/complete/abort rules at the edge, check busy after.
    task automatic step();
        logic [143:0] e;
        @(posedge clk);
        if (!rst_n) begin
            if (model_busy) void'(exp_q.pop_back());
            model_busy = 1'b0;
        end else if (model_busy) begin
            model_busy = 1'b0;
        end else if (start) begin
            for (int i = 0; i < 9; i++) e[16*i +: 16] = ref_mul(a[i], b[i]);
            exp_q.push_back(e);
            model_busy = 1'b1;
        end
        @(negedge clk);
        check("busy", {143'd0, busy}, {143'd0, model_busy});
    endtask

    task automatic set_all(input logic [15:0] x, input logic [15:0] y);
        for (int i = 0; i < 9; i++) begin
            a[i] = x;
            b[i] = y;
        end
    endtask

    task automatic issue();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    // Monitor: tracks the value outputs must hold, updating it on completion or reset.
    initial begin
        logic [143:0] held;
        logic         r;
        logic         busy_prev;
        held      = '0;
        busy_prev = 1'b0;
        forever begin
            @(posedge clk);
            r = rst_n;
            #1;
            if (!r) begin
                held = '0;
            end else if (busy_prev && !busy) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_completion: got busy fall expected none");
                end else begin
                    held = exp_q.pop_front();
                end
            end
            check("outputs", outs_packed(), held);
            busy_prev = busy;
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        set_all(16'h0, 16'h0);
        step();
        step();
        check("reset_outputs", outs_packed(), '0);
        rst_n = 1'b1;
        step();

        set_all(16'h3000, 16'h2000);
        issue();
        set_all(16'h1000, 16'h2000);
        issue();
        a[0] = 16'hF000;
        issue();

        a[0] = 16'h7000; b[0] = 16'h7000;
        a[1] = 16'h8000; b[1] = 16'h7000;
        a[2] = 16'h0001; b[2] = 16'h0001;
        a[3] = 16'hFFFF; b[3] = 16'h0001;
        a[4] = 16'h8000; b[4] = 16'h8000;
        a[5] = 16'h7FFF; b[5] = 16'h8000;
        issue();

        // Second consecutive start lands while busy and must be dropped.
        set_all(16'h1800, 16'h1000);
        start = 1'b1;
        step();
        set_all(16'h3000, 16'h3000);
        step();
        start = 1'b0;
        step();
        step();

        // Reset during the busy cycle aborts the operation.
        set_all(16'h2000, 16'h2000);
        start = 1'b1;
        step();
        start = 1'b0;
        rst_n = 1'b0;
        step();
        check("abort_outputs", outs_packed(), '0);
        rst_n = 1'b1;
        set_all(16'hE800, 16'h2800);
        issue();

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 9; i++) begin
                a[i] = pick();
                b[i] = pick();
            end
            start = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 39) != 0);
            step();
        end

        start = 1'b0;
        rst_n = 1'b1;
        step();
        step();
        check("queue_drained", 144'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
